// File: rtl/cpu_pkg.sv
// Shared types for the simple CPU core: register index/word types and the operand-fetch state encoding.
package cpu_pkg;
    localparam int OPF_NUMREGS   = 32;
    localparam int OPF_DATAWIDTH = 32;
    localparam int OPF_REG_W     = $clog2(OPF_NUMREGS);

    typedef logic [OPF_REG_W-1:0]     reg_idx_t;
    typedef logic [OPF_DATAWIDTH-1:0] word_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        HOLD = 2'd2
    } opf_state_e;

    localparam reg_idx_t REG_ZERO = '0;
endpackage

// File: rtl/opf_scoreboard.sv
// Per-register busy scoreboard with combinational RAW hazard lookup for two sources.
// OPF_BYPASS_EN: a busy source being written back this cycle is not treated as a hazard.
module opf_scoreboard
    import cpu_pkg::*;
#(
    parameter int NUMREGS = OPF_NUMREGS
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       flush_i,
    input  logic                       set_i,
    input  logic [$clog2(NUMREGS)-1:0] set_idx_i,
    input  logic                       clr_i,
    input  logic [$clog2(NUMREGS)-1:0] clr_idx_i,
    input  logic [$clog2(NUMREGS)-1:0] rs1_i,
    input  logic                       use_rs1_i,
    input  logic [$clog2(NUMREGS)-1:0] rs2_i,
    input  logic                       use_rs2_i,
    output logic                       hazard_o
);
    localparam int AW = $clog2(NUMREGS);
    localparam logic [AW-1:0] RZERO = AW'(REG_ZERO);

    logic [NUMREGS-1:0] busy;
    logic               byp1, byp2;

`ifdef OPF_BYPASS_EN
    assign byp1 = clr_i & (clr_idx_i == rs1_i);
    assign byp2 = clr_i & (clr_idx_i == rs2_i);
`else
    assign byp1 = 1'b0;
    assign byp2 = 1'b0;
`endif

    assign hazard_o = (use_rs1_i & busy[rs1_i] & ~byp1) |
                      (use_rs2_i & busy[rs2_i] & ~byp2);

    // Set is written last so a new producer wins over a same-edge writeback.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            busy <= '0;
        end else if (flush_i) begin
            busy <= '0;
        end else begin
            if (clr_i)
                busy[clr_idx_i] <= 1'b0;
            if (set_i && set_idx_i != RZERO)
                busy[set_idx_i] <= 1'b1;
        end
    end
endmodule

// File: rtl/operand_fetch.sv
// Operand fetch: hazard-checked accept from decode, bank read, valid/ready hand-off to execute.
// Owns the bank write port for writeback. OPF_BYPASS_EN enables zero-stall writeback bypass.
module operand_fetch
    import cpu_pkg::*;
#(
    parameter int NUMREGS   = OPF_NUMREGS,
    parameter int DATAWIDTH = OPF_DATAWIDTH
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       flush_i,
    input  logic                       in_valid_i,
    output logic                       in_ready_o,
    input  logic [$clog2(NUMREGS)-1:0] in_rs1_i,
    input  logic [$clog2(NUMREGS)-1:0] in_rs2_i,
    input  logic                       in_use_rs1_i,
    input  logic                       in_use_rs2_i,
    input  logic [$clog2(NUMREGS)-1:0] in_rd_i,
    input  logic                       in_rd_we_i,
    output logic                       out_valid_o,
    input  logic                       out_ready_i,
    output logic [DATAWIDTH-1:0]       out_op_a_o,
    output logic [DATAWIDTH-1:0]       out_op_b_o,
    output logic [$clog2(NUMREGS)-1:0] out_rd_o,
    output logic                       out_rd_we_o,
    input  logic                       wb_valid_i,
    input  logic [$clog2(NUMREGS)-1:0] wb_addr_i,
    input  logic [DATAWIDTH-1:0]       wb_data_i,
    output logic                       rf_re_a_o,
    output logic [$clog2(NUMREGS)-1:0] rf_raddr_a_o,
    output logic                       rf_re_b_o,
    output logic [$clog2(NUMREGS)-1:0] rf_raddr_b_o,
    input  logic [DATAWIDTH-1:0]       rf_rdata_a_i,
    input  logic [DATAWIDTH-1:0]       rf_rdata_b_i,
    output logic                       rf_we_o,
    output logic [$clog2(NUMREGS)-1:0] rf_waddr_o,
    output logic [DATAWIDTH-1:0]       rf_wdata_o
);
    localparam int AW = $clog2(NUMREGS);

    opf_state_e    state;
    logic          hazard, slot_free, accept;
    logic          lat_use_a, lat_use_b, lat_rd_we;
    logic [AW-1:0] lat_rd;

    opf_scoreboard #(.NUMREGS(NUMREGS)) u_scoreboard (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .flush_i   (flush_i),
        .set_i     (accept & in_rd_we_i),
        .set_idx_i (in_rd_i),
        .clr_i     (wb_valid_i),
        .clr_idx_i (wb_addr_i),
        .rs1_i     (in_rs1_i),
        .use_rs1_i (in_use_rs1_i),
        .rs2_i     (in_rs2_i),
        .use_rs2_i (in_use_rs2_i),
        .hazard_o  (hazard)
    );

    // A new instr may enter while idle, or while the held result is leaving this cycle.
    assign slot_free  = (state == IDLE) | ((state == HOLD) & out_ready_i);
    assign in_ready_o = ~flush_i & slot_free & ~hazard;
    assign accept     = in_valid_i & in_ready_o;

    assign rf_re_a_o    = accept & in_use_rs1_i;
    assign rf_raddr_a_o = in_rs1_i;
    assign rf_re_b_o    = accept & in_use_rs2_i;
    assign rf_raddr_b_o = in_rs2_i;

    assign rf_we_o    = wb_valid_i & (wb_addr_i != '0);
    assign rf_waddr_o = wb_addr_i;
    assign rf_wdata_o = wb_data_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state       <= IDLE;
            out_valid_o <= 1'b0;
            out_op_a_o  <= '0;
            out_op_b_o  <= '0;
            out_rd_o    <= '0;
            out_rd_we_o <= 1'b0;
            lat_use_a   <= 1'b0;
            lat_use_b   <= 1'b0;
            lat_rd      <= '0;
            lat_rd_we   <= 1'b0;
        end else if (flush_i) begin
            state       <= IDLE;
            out_valid_o <= 1'b0;
        end else begin
            if (accept) begin
                lat_use_a <= in_use_rs1_i;
                lat_use_b <= in_use_rs2_i;
                lat_rd    <= in_rd_i;
                lat_rd_we <= in_rd_we_i;
            end
            case (state)
                IDLE: begin
                    if (accept)
                        state <= READ;
                end
                READ: begin
                    out_op_a_o  <= lat_use_a ? rf_rdata_a_i : '0;
                    out_op_b_o  <= lat_use_b ? rf_rdata_b_i : '0;
                    out_rd_o    <= lat_rd;
                    out_rd_we_o <= lat_rd_we;
                    out_valid_o <= 1'b1;
                    state       <= HOLD;
                end
                HOLD: begin
                    if (out_ready_i) begin
                        out_valid_o <= 1'b0;
                        state       <= accept ? READ : IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_operand_fetch.sv
// Self-checking bench for operand_fetch: directed scenarios plus randomized traffic against a
// transaction-level model (pending-producer set, register values, one in-flight result).
module tb_operand_fetch;
    import cpu_pkg::*;

`ifdef OPF_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic     clk_i = 1'b0;
    logic     rst_i;
    logic     flush_i, in_valid_i, in_ready_o, in_use_rs1_i, in_use_rs2_i, in_rd_we_i;
    reg_idx_t in_rs1_i, in_rs2_i, in_rd_i;
    logic     out_valid_o, out_ready_i, out_rd_we_o;
    word_t    out_op_a_o, out_op_b_o;
    reg_idx_t out_rd_o;
    logic     wb_valid_i;
    reg_idx_t wb_addr_i;
    word_t    wb_data_i;
    logic     rf_re_a_o, rf_re_b_o, rf_we_o;
    reg_idx_t rf_raddr_a_o, rf_raddr_b_o, rf_waddr_o;
    word_t    rf_rdata_a_i = '0;
    word_t    rf_rdata_b_i = '0;
    word_t    rf_wdata_o;

    operand_fetch dut (
        .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
        .in_rs1_i(in_rs1_i), .in_rs2_i(in_rs2_i),
        .in_use_rs1_i(in_use_rs1_i), .in_use_rs2_i(in_use_rs2_i),
        .in_rd_i(in_rd_i), .in_rd_we_i(in_rd_we_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .out_op_a_o(out_op_a_o), .out_op_b_o(out_op_b_o),
        .out_rd_o(out_rd_o), .out_rd_we_o(out_rd_we_o),
        .wb_valid_i(wb_valid_i), .wb_addr_i(wb_addr_i), .wb_data_i(wb_data_i),
        .rf_re_a_o(rf_re_a_o), .rf_raddr_a_o(rf_raddr_a_o),
        .rf_re_b_o(rf_re_b_o), .rf_raddr_b_o(rf_raddr_b_o),
        .rf_rdata_a_i(rf_rdata_a_i), .rf_rdata_b_i(rf_rdata_b_i),
        .rf_we_o(rf_we_o), .rf_waddr_o(rf_waddr_o), .rf_wdata_o(rf_wdata_o)
    );

    always #5 clk_i = ~clk_i;

    // Register bank: registered read with write-through, driven from the DUT's ports.
    word_t    bank [OPF_NUMREGS] = '{default: '0};
    logic     s_re_a = 1'b0, s_re_b = 1'b0, s_we = 1'b0;
    reg_idx_t s_ra = '0, s_rb = '0, s_wa = '0;
    word_t    s_wd = '0;

    always @(negedge clk_i) begin
        s_re_a = rf_re_a_o; s_ra = rf_raddr_a_o;
        s_re_b = rf_re_b_o; s_rb = rf_raddr_b_o;
        s_we   = rf_we_o;   s_wa = rf_waddr_o; s_wd = rf_wdata_o;
    end

    always @(posedge clk_i) begin
        if (s_re_a) rf_rdata_a_i <= (s_we && s_wa == s_ra) ? s_wd : bank[s_ra];
        if (s_re_b) rf_rdata_b_i <= (s_we && s_wa == s_rb) ? s_wd : bank[s_rb];
        if (s_we) bank[s_wa] <= s_wd;
    end

    // Reference model state
    word_t                  mem [OPF_NUMREGS] = '{default: '0};
    logic [OPF_NUMREGS-1:0] pend = '0;
    bit                     have_instr = 1'b0;
    int                     vis_cyc = 0, cyc = 0;
    word_t                  ea = '0, eb = '0;
    reg_idx_t               erd = '0;
    bit                     erdwe = 1'b0;
    bit                     e_valid, e_ready, dut_acc = 1'b0, auto_wb = 1'b0;
    reg_idx_t               wbq [$];
    int                     checks = 0, errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic bit src_haz(input bit use_r, input reg_idx_t r);
        return use_r && pend[r] && !(BYP && wb_valid_i && wb_addr_i == r);
    endfunction

    function automatic word_t rd_val(input reg_idx_t r);
        if (wb_valid_i && r != '0 && wb_addr_i == r) return wb_data_i;
        return mem[r];
    endfunction

    task automatic check_cycle();
        bit acc;
        e_valid = have_instr && (cyc >= vis_cyc);
        chk("out_valid", 32'(out_valid_o), 32'(e_valid));
        if (e_valid) begin
            chk("op_a", out_op_a_o, ea);
            chk("op_b", out_op_b_o, eb);
            chk("out_rd", 32'(out_rd_o), 32'(erd));
            chk("out_rd_we", 32'(out_rd_we_o), 32'(erdwe));
        end
        e_ready = !flush_i && (!have_instr || (e_valid && out_ready_i)) &&
                  !src_haz(in_use_rs1_i, in_rs1_i) && !src_haz(in_use_rs2_i, in_rs2_i);
        chk("in_ready", 32'(in_ready_o), 32'(e_ready));
        acc = in_valid_i && e_ready;
        chk("rf_re_a", 32'(rf_re_a_o), 32'(acc && in_use_rs1_i));
        chk("rf_re_b", 32'(rf_re_b_o), 32'(acc && in_use_rs2_i));
        if (acc && in_use_rs1_i) chk("rf_raddr_a", 32'(rf_raddr_a_o), 32'(in_rs1_i));
        if (acc && in_use_rs2_i) chk("rf_raddr_b", 32'(rf_raddr_b_o), 32'(in_rs2_i));
        chk("rf_we", 32'(rf_we_o), 32'(wb_valid_i && wb_addr_i != '0));
        if (wb_valid_i && wb_addr_i != '0) begin
            chk("rf_waddr", 32'(rf_waddr_o), 32'(wb_addr_i));
            chk("rf_wdata", rf_wdata_o, wb_data_i);
        end
        dut_acc = in_valid_i && in_ready_o;
    endtask

    task automatic update_model();
        bit acc;
        acc = in_valid_i && e_ready;
        if (flush_i) begin
            have_instr = 1'b0;
            pend       = '0;
        end else begin
            if (e_valid && out_ready_i) begin
                have_instr = 1'b0;
                if (auto_wb && erdwe && erd != '0) wbq.push_back(erd);
            end
            if (acc) begin
                have_instr = 1'b1;
                vis_cyc    = cyc + 2;
                ea    = in_use_rs1_i ? rd_val(in_rs1_i) : '0;
                eb    = in_use_rs2_i ? rd_val(in_rs2_i) : '0;
                erd   = in_rd_i;
                erdwe = in_rd_we_i;
            end
            if (wb_valid_i) pend[wb_addr_i] = 1'b0;
            if (acc && in_rd_we_i && in_rd_i != '0) pend[in_rd_i] = 1'b1;
        end
        if (wb_valid_i && wb_addr_i != '0) mem[wb_addr_i] = wb_data_i;
        cyc++;
    endtask

    task automatic tick();
        @(negedge clk_i);
        check_cycle();
        @(posedge clk_i);
        update_model();
        #1;
    endtask

    task automatic idle_in();
        in_valid_i = 0; in_use_rs1_i = 0; in_use_rs2_i = 0; in_rs1_i = '0; in_rs2_i = '0;
        in_rd_i = '0; in_rd_we_i = 0; wb_valid_i = 0; wb_addr_i = '0; wb_data_i = '0;
        flush_i = 0; out_ready_i = 1;
    endtask

    task automatic set_instr(input int rs1, input bit u1, input int rs2, input bit u2,
                             input int rd, input bit we);
        in_rs1_i = reg_idx_t'(rs1); in_use_rs1_i = u1;
        in_rs2_i = reg_idx_t'(rs2); in_use_rs2_i = u2;
        in_rd_i  = reg_idx_t'(rd);  in_rd_we_i   = we;
        in_valid_i = 1'b1;
    endtask

    task automatic wb(input int a, input word_t d);
        wb_valid_i = 1'b1; wb_addr_i = reg_idx_t'(a); wb_data_i = d;
        tick();
        wb_valid_i = 1'b0;
    endtask

    task automatic issue(input string tag);
        int n = 0;
        dut_acc = 1'b0;
        while (!dut_acc && n < 12) begin tick(); n++; end
        chk({tag, "_accept"}, 32'(dut_acc), 32'd1);
        in_valid_i = 1'b0;
    endtask

    task automatic wait_out(input string tag);
        int n = 0;
        while (!out_valid_o && n < 8) begin tick(); n++; end
        chk({tag, "_out_valid"}, 32'(out_valid_o), 32'd1);
    endtask

    initial begin
        idle_in();
        rst_i = 1'b1;
        repeat (3) @(posedge clk_i);
        #1;
        chk("rst_out_valid", 32'(out_valid_o), 32'd0);
        chk("rst_op_a", out_op_a_o, 32'd0);
        chk("rst_op_b", out_op_b_o, 32'd0);
        chk("rst_out_rd", 32'(out_rd_o), 32'd0);
        chk("rst_out_rd_we", 32'(out_rd_we_o), 32'd0);
        chk("rst_rf_re_a", 32'(rf_re_a_o), 32'd0);
        chk("rst_rf_re_b", 32'(rf_re_b_o), 32'd0);
        rst_i = 1'b0;

        // 1: basic read, result visible two cycles after accept
        wb(3, 32'd3); wb(5, 32'd5);
        set_instr(3, 1, 5, 1, 1, 0); issue("t1");
        chk("t1_n1_valid", 32'(out_valid_o), 32'd0);
        tick();
        chk("t1_n2_valid", 32'(out_valid_o), 32'd1);
        chk("t1_op_a", out_op_a_o, 32'd3);
        chk("t1_op_b", out_op_b_o, 32'd5);
        tick();

        // 2: RAW stall on r7 until writeback
        set_instr(0, 0, 0, 0, 7, 1); issue("t2a");
        set_instr(7, 1, 0, 0, 2, 0);
        tick(); tick();
        chk("t2_stall", 32'(in_ready_o), 32'd0);
        tick();
        wb_valid_i = 1'b1; wb_addr_i = 5'd7; wb_data_i = 32'hAA;
        #1 chk("t2_wb_ready", 32'(in_ready_o), 32'(BYP));
        tick();
        wb_valid_i = 1'b0;
        if (!dut_acc) issue("t2b"); else in_valid_i = 1'b0;
        wait_out("t2");
        chk("t2_op_a", out_op_a_o, 32'hAA);
        tick();

        // 3: downstream backpressure, then same-cycle accept on release
        out_ready_i = 1'b0;
        set_instr(1, 1, 2, 1, 3, 0); issue("t3a");
        wait_out("t3a");
        set_instr(3, 1, 0, 0, 4, 0);
        repeat (4) begin
            #1 chk("t3_hold_ready", 32'(in_ready_o), 32'd0);
            chk("t3_hold_valid", 32'(out_valid_o), 32'd1);
            tick();
        end
        out_ready_i = 1'b1;
        #1 chk("t3_release_ready", 32'(in_ready_o), 32'd1);
        tick();
        chk("t3_same_cycle", 32'(dut_acc), 32'd1);
        in_valid_i = 1'b0;
        wait_out("t3b"); tick();

        // 4: r0 is never busy and never written
        set_instr(0, 0, 0, 0, 0, 1); issue("t4a");
        set_instr(0, 1, 0, 1, 5, 0);
        wb_valid_i = 1'b1; wb_addr_i = '0; wb_data_i = 32'h55;
        #1 chk("t4_rf_we_r0", 32'(rf_we_o), 32'd0);
        tick();
        wb_valid_i = 1'b0;
        tick();
        chk("t4_no_stall", 32'(dut_acc), 32'd1);
        in_valid_i = 1'b0;
        wait_out("t4");
        chk("t4_op_a", out_op_a_o, 32'd0);
        chk("t4_op_b", out_op_b_o, 32'd0);
        tick();

        // 5: flush drops held result and clears busy
        out_ready_i = 1'b0;
        set_instr(0, 0, 0, 0, 4, 1); issue("t5a");
        wait_out("t5a");
        flush_i = 1'b1; tick(); flush_i = 1'b0;
        chk("t5_flush_valid", 32'(out_valid_o), 32'd0);
        out_ready_i = 1'b1;
        set_instr(4, 1, 0, 0, 1, 0);
        #1 chk("t5_ready_after_flush", 32'(in_ready_o), 32'd1);
        issue("t5b"); wait_out("t5b"); tick();

        // 6: writeback coincident with a dependent source
        set_instr(0, 0, 0, 0, 9, 1); issue("t6a");
        wait_out("t6a"); tick();
        set_instr(9, 1, 0, 0, 2, 0);
        wb_valid_i = 1'b1; wb_addr_i = 5'd9; wb_data_i = 32'h1234_5678;
        #1 chk("t6_wb_ready", 32'(in_ready_o), 32'(BYP));
        tick();
        wb_valid_i = 1'b0;
        if (!dut_acc) issue("t6b"); else in_valid_i = 1'b0;
        wait_out("t6");
        chk("t6_op_a", out_op_a_o, 32'h1234_5678);
        tick();

        // Random traffic over r0..r7
        auto_wb = 1'b1;
        repeat (3000) begin
            flush_i      = ($urandom_range(0, 49) == 0);
            in_valid_i   = ($urandom_range(0, 2) != 0);
            in_rs1_i     = reg_idx_t'($urandom_range(0, 7));
            in_rs2_i     = reg_idx_t'($urandom_range(0, 7));
            in_use_rs1_i = $urandom_range(0, 1) != 0;
            in_use_rs2_i = $urandom_range(0, 1) != 0;
            in_rd_i      = reg_idx_t'($urandom_range(0, 7));
            in_rd_we_i   = $urandom_range(0, 1) != 0;
            out_ready_i  = ($urandom_range(0, 3) != 0);
            if (wbq.size() > 0 && $urandom_range(0, 1) != 0) begin
                wb_valid_i = 1'b1; wb_addr_i = wbq.pop_front(); wb_data_i = $urandom;
            end else if ($urandom_range(0, 15) == 0) begin
                wb_valid_i = 1'b1; wb_addr_i = reg_idx_t'($urandom_range(0, 7)); wb_data_i = $urandom;
            end else begin
                wb_valid_i = 1'b0;
            end
            tick();
        end
        auto_wb = 1'b0;

        // Async reset while a result is held
        idle_in();
        tick(); tick(); tick();
        out_ready_i = 1'b0;
        set_instr(1, 1, 0, 0, 3, 0); issue("arst");
        wait_out("arst");
        #2 rst_i = 1'b1;
        #1 chk("arst_out_valid", 32'(out_valid_o), 32'd0);
        chk("arst_op_a", out_op_a_o, 32'd0);
        @(posedge clk_i);
        #1 rst_i = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
